// File: rtl/nonrestoring_divider_seq.sv
// nonrestoring_divider_seq
// Sequential unsigned divider using non-restoring division. It produces one
// quotient bit per clock. A SIZE+1-bit two's-complement partial remainder P
// selects add or subtract on each step. A final FIX cycle corrects a negative
// remainder. A zero divisor skips the iteration loop and reports all-ones
// quotient with the dividend as remainder one cycle after acceptance.
module nonrestoring_divider_seq #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            div_by_zero
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    logic [SIZE:0]   p;
    logic [SIZE-1:0] q;
    logic [SIZE-1:0] d;
    logic [CW-1:0]   cnt;
    logic            dz_pending;

    logic [SIZE:0]   d_ext;
    logic [SIZE:0]   p_shift;
    logic [SIZE:0]   p_step;
    logic [SIZE:0]   p_fix;

    assign busy  = (state != IDLE);
    assign d_ext = {1'b0, d};

    // Single add/subtract datapath: the sign of the current remainder picks the operation.
    always_comb begin
        p_shift = {p[SIZE-1:0], q[SIZE-1]};
        p_step  = p[SIZE] ? (p_shift + d_ext) : (p_shift - d_ext);
        p_fix   = p[SIZE] ? (p + d_ext) : p;
    end

    // Control FSM, iteration registers, and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            p           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            dz_pending  <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done       <= 1'b0;
            dz_pending <= 1'b0;

            // A divide-by-zero request reports one edge after acceptance.
            // q still holds the captured dividend at that point, even if a
            // new request loads q on the same edge.
            if (dz_pending) begin
                quotient    <= '1;
                remainder   <= q;
                div_by_zero <= 1'b1;
                done        <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        q <= dividend;
                        if (divisor != '0) begin
                            d     <= divisor;
                            p     <= '0;
                            cnt   <= CW'(SIZE);
                            state <= RUN;
                        end else begin
                            dz_pending <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    p   <= p_step;
                    q   <= {q[SIZE-2:0], ~p_step[SIZE]};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    p           <= p_fix;
                    quotient    <= q;
                    remainder   <= p_fix[SIZE-1:0];
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider_seq.sv
// tb_nonrestoring_divider_seq
// Scoreboard bench for the SIZE=4 divider. The driver pushes the expected result
// and the expected done time for every accepted request. A monitor pops and
// compares on every done pulse and also checks the pulse width.
module tb_nonrestoring_divider_seq;

    localparam int SIZE   = 4;
    localparam int PERIOD = 10;

    logic            clk;
    logic            rst;
    logic            start;
    logic [SIZE-1:0] dividend;
    logic [SIZE-1:0] divisor;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;
    logic            div_by_zero;

    typedef struct {
        logic [SIZE-1:0] q;
        logic [SIZE-1:0] r;
        logic            dz;
        time             t;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic prev_done = 1'b0;

    nonrestoring_divider_seq #(.SIZE(SIZE)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #(PERIOD / 2) clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    // Caller is positioned at a negedge. Drive one request, then record the expected result at the accepting edge.
    task automatic applyStimulus(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
            e.t  = $time + PERIOD + PERIOD / 2;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
            e.t  = $time + (SIZE + 1) * PERIOD + PERIOD / 2;
        end
        sb.push_back(e);
        #1 start = 1'b0;
    endtask

    task automatic waitDrained();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                checks++;
                if (prev_done) begin
                    failures++;
                    $display("[TB] FAIL done_width: got done high 2 cycles, expected 1");
                end
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected done=0 at time %0t", $time);
                end else begin
                    e = sb.pop_front();
                    checkOutput("quotient", 64'(quotient), 64'(e.q));
                    checkOutput("remainder", 64'(remainder), 64'(e.r));
                    checkOutput("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                    checkOutput("done_time", 64'($time), 64'(e.t));
                    checkOutput("busy_at_done", 64'(busy), 64'(0));
                end
            end
            prev_done = done;
        end
    end

    // Directed stimulus followed by an exhaustive sweep.
    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_quotient", 64'(quotient), 64'(0));
        checkOutput("reset_remainder", 64'(remainder), 64'(0));
        checkOutput("reset_dz", 64'(div_by_zero), 64'(0));

        // 13/3, with busy held for exactly SIZE+1 cycles.
        @(negedge clk);
        applyStimulus(4'd13, 4'd3);
        for (int i = 0; i < SIZE + 1; i++) begin
            @(negedge clk);
            checkOutput("busy_run", 64'(busy), 64'(1));
        end
        @(negedge clk);
        checkOutput("busy_after", 64'(busy), 64'(0));
        waitDrained();

        // 7/9 leaves a negative partial remainder that FIX must correct.
        @(negedge clk);
        applyStimulus(4'd7, 4'd9);
        waitDrained();

        // 15/1, then divide by zero.
        @(negedge clk);
        applyStimulus(4'd15, 4'd1);
        waitDrained();
        @(negedge clk);
        applyStimulus(4'd10, 4'd0);
        @(negedge clk);
        checkOutput("dz_busy", 64'(busy), 64'(0));
        waitDrained();

        // 14/4 with a start pulse during busy that must be ignored.
        @(negedge clk);
        applyStimulus(4'd14, 4'd4);
        @(negedge clk);
        @(negedge clk);
        dividend = 4'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 20);
            checkOutput("done_seen_14_4", 64'(done), 64'(1));
        end
        // A request issued in the done cycle is accepted.
        applyStimulus(4'd9, 4'd2);
        waitDrained();

        // Reset in the middle of 12/5 aborts it silently.
        @(negedge clk);
        applyStimulus(4'd12, 4'd5);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        checkOutput("abort_quotient", 64'(quotient), 64'(0));
        checkOutput("abort_remainder", 64'(remainder), 64'(0));
        checkOutput("abort_dz", 64'(div_by_zero), 64'(0));
        repeat (8) @(negedge clk);
        applyStimulus(4'd12, 4'd5);
        waitDrained();

        // Exhaustive sweep of all operand pairs.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(negedge clk);
                applyStimulus(4'(a), 4'(b));
                waitDrained();
            end
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
